pot_scan_sched: RTL

- Round-robin scheduler that owns the shared SPI A2D interface.
- Cycles conversions over the six slide-pot channels (LP, B1, B2, B3, HP, VOL) and holds each result in a dedicated 12-bit register.
- Registers drive the POT_* gain and volume inputs of the EQ engine.
- Handles pacing between conversions, conversion timeout and first-sweep-valid signalling, so the EQ datapath only ever sees stable, registered pot values.

---
 rtl/pot_scan_sched.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pot_scan_sched.sv
// Round-robin owner of the shared SPI A2D: scans the six slide pots and holds each result
// in a registered 12-bit value for the EQ engine.
//   state   | meaning
//   IDLE    | scanning stopped, waiting for en
//   START   | strt_cnv pulse for the channel at idx
//   WAIT    | conversion in flight, timeout counter running
//   GAP     | pacing delay before the next conversion
module pot_scan_sched #(
    parameter logic [2:0] CH_LP      = 3'd1,
    parameter logic [2:0] CH_B1      = 3'd0,
    parameter logic [2:0] CH_B2      = 3'd4,
    parameter logic [2:0] CH_B3      = 3'd2,
    parameter logic [2:0] CH_HP      = 3'd3,
    parameter logic [2:0] CH_VOL     = 3'd7,
    parameter int         GAP_CYCLES = 16,
    parameter int         TO_CYCLES  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic [11:0] POT_LP,
    output logic [11:0] POT_B1,
    output logic [11:0] POT_B2,
    output logic [11:0] POT_B3,
    output logic [11:0] POT_HP,
    output logic [11:0] POT_VOL,
    output logic        pots_vld,
    output logic        timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    localparam int             TW       = $clog2(TO_CYCLES);
    localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0]  TO_LAST  = TW'(TO_CYCLES - 1);
    localparam logic [GW-1:0]  GAP_LOAD = (GAP_CYCLES > 1) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [2:0]     IDX_VOL  = 3'd5;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [TW-1:0]      to_cnt_q, to_cnt_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [5:0][11:0]   pot_q, pot_d;
    logic [5:0]         cap_mask_q, cap_mask_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;
    logic               strt_q, strt_d;
    logic [2:0]         chnnl_q, chnnl_d;

    logic               done, tmo;

    function automatic logic [2:0] ch_of(input logic [2:0] idx);
        case (idx)
            3'd0:    ch_of = CH_LP;
            3'd1:    ch_of = CH_B1;
            3'd2:    ch_of = CH_B2;
            3'd3:    ch_of = CH_B3;
            3'd4:    ch_of = CH_HP;
            3'd5:    ch_of = CH_VOL;
            default: ch_of = CH_LP;
        endcase
    endfunction

    // A completion on the timeout edge counts as a capture, not a timeout.
    assign done = (state_q == S_WAIT) && cnv_cmplt;
    assign tmo  = (state_q == S_WAIT) && !cnv_cmplt && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            pot_q      <= '0;
            cap_mask_q <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            strt_q     <= 1'b0;
            chnnl_q    <= CH_LP;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            pot_q      <= pot_d;
            cap_mask_q <= cap_mask_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
            strt_q     <= strt_d;
            chnnl_q    <= chnnl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (done || tmo) state_d = S_GAP;
            S_GAP:   if (gap_cnt_q == '0) state_d = en ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d      = idx_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pot_d      = pot_q;
        cap_mask_d = cap_mask_q;
        vld_d      = vld_q;
        err_d      = err_q;

        if (done || tmo)
            idx_d = (idx_q == IDX_VOL) ? 3'd0 : idx_q + 3'd1;

        // Timeout counter reads the clocks elapsed since the strt_cnv cycle.
        if (state_d == S_START)
            to_cnt_d = '0;
        else if (state_q == S_START || state_q == S_WAIT)
            to_cnt_d = to_cnt_q + 1'b1;

        if (done || tmo)
            gap_cnt_d = GAP_LOAD;
        else if (state_q == S_GAP && gap_cnt_q != '0)
            gap_cnt_d = gap_cnt_q - 1'b1;

        if (done) begin
            pot_d[idx_q]      = res;
            cap_mask_d[idx_q] = 1'b1;
            err_d             = 1'b0;
            if (idx_q == IDX_VOL && (&cap_mask_d))
                vld_d = 1'b1;
        end else if (tmo) begin
            err_d = 1'b1;
        end

        strt_d  = (state_d == S_START);
        chnnl_d = ch_of(idx_d);
    end

    assign strt_cnv    = strt_q;
    assign chnnl       = chnnl_q;
    assign POT_LP      = pot_q[0];
    assign POT_B1      = pot_q[1];
    assign POT_B2      = pot_q[2];
    assign POT_B3      = pot_q[3];
    assign POT_HP      = pot_q[4];
    assign POT_VOL     = pot_q[5];
    assign pots_vld    = vld_q;
    assign timeout_err = err_q;

endmodule
